// File: rtl/cbrt_dispatch.sv
`timescale 1ns/1ps
// cbrt_dispatch_fifo: operand buffer, pointers carry an extra wrap bit to tell full from empty.
// Latency: data written at edge T is readable after edge T (no bypass, first pop at edge T+1).
// Backpressure: o_push_rdy low while full; simultaneous push and pop both honoured.
module cbrt_dispatch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push_vld,
  input  logic [W-1:0] i_push_dat,
  output logic         o_push_rdy,
  input  logic         i_pop,
  output logic         o_pop_vld,
  output logic [W-1:0] o_pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push     = i_push_vld && !w_full;
  assign w_pop      = i_pop && !w_empty;
  assign o_push_rdy = !w_full;
  assign o_pop_vld  = !w_empty;
  assign o_pop_dat  = r_mem[r_rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end
  end

  // Pointer update; wrap bit toggles every DEPTH entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// cbrt_dispatch: buffers operands, issues them one at a time to the cbrt core, returns root+operand.
// Latency: push into empty FIFO -> start pulse 2 cycles later; result valid 1 cycle after busy drops.
// Backpressure: in_ready_o low when FIFO full; result held in OUT until res_ready_i.
module cbrt_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic [7:0]  cbrt_x_o,
  output logic        cbrt_start_o,
  output logic        cbrt_rst_o,
  input  logic        cbrt_busy_i,
  input  logic [2:0]  cbrt_result_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [2:0]  res_root_o,
  output logic [7:0]  res_x_o,
  output logic        res_timeout_o,
  output logic [15:0] done_cnt_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  state_t        r_state;
  logic [7:0]    r_x;
  logic          r_start;
  logic          r_abort;
  logic          r_res_valid;
  logic [2:0]    r_root;
  logic [7:0]    r_res_x;
  logic          r_timeout;
  logic [15:0]   r_done;
  logic [CW-1:0] r_wait_cnt;

  logic          w_fifo_vld;
  logic [7:0]    w_fifo_dat;
  logic          w_pop;

  // The FSM only consumes an operand while idle, so pop is a pure function of state.
  assign w_pop = (r_state == S_IDLE) && w_fifo_vld;

  cbrt_dispatch_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (in_valid_i),
    .i_push_dat (in_data_i),
    .o_push_rdy (in_ready_o),
    .i_pop      (w_pop),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_fifo_dat)
  );

  // Issue sequencer: IDLE -> ISSUE -> SETTLE -> WAIT -> OUT, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_start     <= 1'b0;
      r_abort     <= 1'b0;
      r_res_valid <= 1'b0;
      r_root      <= '0;
      r_res_x     <= '0;
      r_timeout   <= 1'b0;
      r_done      <= '0;
      r_wait_cnt  <= '0;
    end else begin
      // Start and abort are single-cycle pulses unless re-armed below.
      r_start <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fifo_vld) begin
            r_x     <= w_fifo_dat;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          // Core raises busy during this cycle, so busy is not trusted until WAIT.
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!cbrt_busy_i) begin
            r_root      <= cbrt_result_i;
            r_res_x     <= r_x;
            r_timeout   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
            // Hung core: report a zero root and kick the core with a reset pulse.
            r_root      <= '0;
            r_res_x     <= r_x;
            r_timeout   <= 1'b1;
            r_abort     <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        S_OUT: begin
          if (res_ready_i) begin
            r_res_valid <= 1'b0;
            if (r_done != 16'hFFFF) r_done <= r_done + 16'd1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cbrt_x_o      = r_x;
  assign cbrt_start_o  = r_start;
  assign cbrt_rst_o    = rst | r_abort;
  assign res_valid_o   = r_res_valid;
  assign res_root_o    = r_root;
  assign res_x_o       = r_res_x;
  assign res_timeout_o = r_timeout;
  assign done_cnt_o    = r_done;
endmodule

// File: tb/tb_cbrt_dispatch.sv
`timescale 1ns/1ps
// tb_cbrt_dispatch: directed tests with a behavioural core stub and a queue-based result model.
// Latency: model expects start-to-valid of core latency+1, or TIMEOUT+2 for a hung core.
// Backpressure: occupancy model predicts in_ready_o every cycle; res_ready_i driven per test.
module tb_cbrt_dispatch;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid_i;
  logic [7:0]  in_data_i;
  logic        in_ready_o;
  logic [7:0]  cbrt_x_o;
  logic        cbrt_start_o;
  logic        cbrt_rst_o;
  logic        cbrt_busy_i;
  logic [2:0]  cbrt_result_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [2:0]  res_root_o;
  logic [7:0]  res_x_o;
  logic        res_timeout_o;
  logic [15:0] done_cnt_o;

  cbrt_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid_i),
    .in_data_i     (in_data_i),
    .in_ready_o    (in_ready_o),
    .cbrt_x_o      (cbrt_x_o),
    .cbrt_start_o  (cbrt_start_o),
    .cbrt_rst_o    (cbrt_rst_o),
    .cbrt_busy_i   (cbrt_busy_i),
    .cbrt_result_i (cbrt_result_i),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_root_o    (res_root_o),
    .res_x_o       (res_x_o),
    .res_timeout_o (res_timeout_o),
    .done_cnt_o    (done_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic int cbrt_ref(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int core_lat(input int x);
    return 2 + (x % 3);
  endfunction

  // Core stub: busy from the start pulse for core_lat cycles, or forever while hang is set.
  logic       hang = 1'b0;
  int         core_cnt;
  logic [7:0] core_x;
  initial begin
    cbrt_busy_i   = 1'b0;
    cbrt_result_i = 3'd0;
    core_cnt      = 0;
    core_x        = 8'd0;
    forever begin
      @(negedge clk);
      if (cbrt_rst_o) begin
        cbrt_busy_i = 1'b0;
        core_cnt    = 0;
      end else if (cbrt_start_o) begin
        core_x      = cbrt_x_o;
        cbrt_busy_i = 1'b1;
        core_cnt    = core_lat(int'(cbrt_x_o));
      end else if (cbrt_busy_i && !hang && core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          cbrt_busy_i   = 1'b0;
          cbrt_result_i = 3'(cbrt_ref(int'(core_x)));
        end
      end
    end
  end

  // Behavioural model and the single compare process.
  typedef struct {
    int x;
    int hung;
    int lat;
    int start_cyc;
  } iss_t;

  int   in_q[$];
  iss_t iss_q[$];
  int   obs_x[$];
  int   obs_root[$];
  int   obs_to[$];
  int   acc = 0, pops = 0, model_done = 0, cyc = 0, n_starts = 0, n_core_rst = 0;
  logic prev_valid = 1'b0;

  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_q.delete();
        iss_q.delete();
        acc        = 0;
        pops       = 0;
        model_done = 0;
        prev_valid = 1'b0;
      end else begin
        if (cbrt_rst_o) n_core_rst++;
        if (cbrt_start_o) begin
          n_starts++;
          pops++;
          check("start_while_outstanding", iss_q.size(), 0);
          if (in_q.size() == 0) begin
            fail_now("start_without_operand");
          end else begin
            check("start_x", int'(cbrt_x_o), in_q[0]);
            e.x         = in_q[0];
            e.hung      = int'(hang);
            e.lat       = core_lat(in_q[0]);
            e.start_cyc = cyc;
            iss_q.push_back(e);
            void'(in_q.pop_front());
          end
        end
        check("in_ready", int'(in_ready_o), int'((acc - pops) < DEPTH));
        check("done_cnt", int'(done_cnt_o), model_done);
        if (res_valid_o) begin
          if (iss_q.size() == 0) begin
            fail_now("res_valid_without_issue");
          end else begin
            e = iss_q[0];
            check("res_root", int'(res_root_o), e.hung != 0 ? 0 : cbrt_ref(e.x));
            check("res_x", int'(res_x_o), e.x);
            check("res_timeout", int'(res_timeout_o), e.hung);
            check("core_rst_pulse", int'(cbrt_rst_o), int'(!prev_valid && e.hung != 0));
            if (!prev_valid)
              check("res_latency", cyc - e.start_cyc, e.hung != 0 ? TIMEOUT + 2 : e.lat + 1);
            if (res_ready_i) begin
              obs_x.push_back(int'(res_x_o));
              obs_root.push_back(int'(res_root_o));
              obs_to.push_back(int'(res_timeout_o));
              void'(iss_q.pop_front());
              model_done++;
            end
          end
        end else begin
          check("core_rst_idle", int'(cbrt_rst_o), 0);
        end
        prev_valid = res_valid_o;
        if (in_valid_i && in_ready_o) begin
          in_q.push_back(int'(in_data_i));
          acc++;
        end
      end
    end
  end

  // Drivers (called at posedge+1; return at posedge+1).
  task automatic push(input logic [7:0] x);
    int n = 0;
    in_valid_i = 1'b1;
    in_data_i  = x;
    @(negedge clk);
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) fail_now("push_accept_timeout");
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_obs(input int n, input string name);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (obs_x.size() < n && k < 2000);
    check(name, int'(obs_x.size() >= n), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  int'(in_ready_o), 1);
    check({tag, "_cbrt_x"},    int'(cbrt_x_o), 0);
    check({tag, "_start"},     int'(cbrt_start_o), 0);
    check({tag, "_res_valid"}, int'(res_valid_o), 0);
    check({tag, "_res_root"},  int'(res_root_o), 0);
    check({tag, "_res_x"},     int'(res_x_o), 0);
    check({tag, "_timeout"},   int'(res_timeout_o), 0);
    check({tag, "_done"},      int'(done_cnt_o), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_x.delete();
    obs_root.delete();
    obs_to.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    int exp_t3[6];
    in_valid_i  = 1'b0;
    in_data_i   = 8'd0;
    res_ready_i = 1'b1;

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_core_rst", int'(cbrt_rst_o), 1);
    check_reset_vals("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: single operand, start two cycles after push.
    do_reset();
    push(8'd27);
    @(negedge clk);
    check("t1_start_early", int'(cbrt_start_o), 0);
    @(negedge clk);
    check("t1_start_cycle", int'(cbrt_start_o), 1);
    @(posedge clk);
    #1;
    wait_obs(1, "t1_result_seen");
    if (obs_x.size() >= 1) begin
      check("t1_root", obs_root[0], 3);
      check("t1_x", obs_x[0], 27);
      check("t1_timeout", obs_to[0], 0);
    end
    @(negedge clk);
    check("t1_done", int'(done_cnt_o), 1);
    @(posedge clk);
    #1;

    // Test 2: back-to-back operands, results in order.
    do_reset();
    push(8'd64);
    push(8'd125);
    push(8'd216);
    push(8'd8);
    wait_obs(4, "t2_results_seen");
    if (obs_x.size() >= 4) begin
      check("t2_root0", obs_root[0], 4);
      check("t2_root1", obs_root[1], 5);
      check("t2_root2", obs_root[2], 6);
      check("t2_root3", obs_root[3], 2);
      check("t2_x3", obs_x[3], 8);
    end
    @(negedge clk);
    check("t2_done", int'(done_cnt_o), 4);
    @(posedge clk);
    #1;

    // Test 3: consumer stalled, FIFO fills after 1 in flight + DEPTH buffered.
    do_reset();
    res_ready_i = 1'b0;
    push(8'd1);
    push(8'd8);
    push(8'd27);
    push(8'd64);
    push(8'd125);
    @(negedge clk);
    check("t3_full_after_5", int'(in_ready_o), 0);
    check("t3_none_returned", obs_x.size(), 0);
    @(posedge clk);
    #1;
    res_ready_i = 1'b1;
    push(8'd216);
    wait_obs(6, "t3_results_seen");
    exp_t3 = '{1, 2, 3, 4, 5, 6};
    if (obs_x.size() >= 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("t3_root%0d", i), obs_root[i], exp_t3[i]);
      check("t3_x5", obs_x[5], 216);
    end

    // Test 4: hung core times out, then the next operand completes.
    do_reset();
    r0 = n_core_rst;
    hang = 1'b1;
    push(8'd100);
    wait_obs(1, "t4_timeout_seen");
    hang = 1'b0;
    push(8'd125);
    wait_obs(2, "t4_recover_seen");
    if (obs_x.size() >= 2) begin
      check("t4_to_flag", obs_to[0], 1);
      check("t4_to_root", obs_root[0], 0);
      check("t4_to_x", obs_x[0], 100);
      check("t4_next_root", obs_root[1], 5);
      check("t4_next_flag", obs_to[1], 0);
    end
    check("t4_core_rst_cycles", n_core_rst - r0, 1);

    // Test 5: reset during WAIT with operands buffered drops everything.
    do_reset();
    hang = 1'b1;
    push(8'd1);
    push(8'd2);
    push(8'd3);
    push(8'd4);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    s0 = n_starts;
    rst = 1'b1;
    @(negedge clk);
    check("t5_core_rst_in_rst", int'(cbrt_rst_o), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    check_reset_vals("t5");
    check("t5_core_rst_after", int'(cbrt_rst_o), 0);
    repeat (25) @(negedge clk);
    check("t5_no_new_start", n_starts - s0, 0);
    check("t5_no_results", obs_x.size(), 0);
    @(posedge clk);
    #1;

    // Test 6: push lands on the same edge as the idle pop of a single entry.
    do_reset();
    push(8'd8);
    push(8'd27);
    wait_obs(2, "t6_results_seen");
    if (obs_x.size() >= 2) begin
      check("t6_x0", obs_x[0], 8);
      check("t6_root0", obs_root[0], 2);
      check("t6_x1", obs_x[1], 27);
      check("t6_root1", obs_root[1], 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
